// File: rtl/inst_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_loader_pkg
// Description : Shared loader definitions: FSM encoding, word geometry and
//               checksum width used by the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_mem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = 8 * WORD_BYTES;
    localparam int CSUM_W     = 32;
    localparam int LEN_W      = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/inst_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_loader_if
// Description : Control, byte-stream and memory-write signals of the
//               instruction-memory loader. The loader uses the slave modport,
//               the host / memory side uses the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_mem_loader_if
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) ();

    logic                start;
    logic [LEN_W-1:0]    len_words;
    logic                byte_valid;
    logic [7:0]          byte_data;
    logic                byte_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [WORD_W-1:0]   mem_wdata;
    logic                cpu_hold;
    logic                done;
    logic                err;

    modport master (
        output start, len_words, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, err
    );

    modport slave (
        input  start, len_words, byte_valid, byte_data,
        output byte_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, err
    );

endinterface
`default_nettype wire

// File: rtl/inst_mem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_loader_byte_packer
// Description : Assembles four little-endian bytes into one word. word_o is
//               the word as it will look after the current byte is loaded,
//               so the caller can capture a complete word in the same cycle
//               word_full_o pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_loader_byte_packer
    import inst_mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_o
);

    logic [1:0]        idx_q;
    logic [WORD_W-1:0] pack_q;

    // Merge the incoming byte into its lane k at bits [8k+7:8k]
    always_comb begin
        word_o = pack_q;
        word_o[{idx_q, 3'b000} +: 8] = byte_i;
    end

    assign word_full_o = load_i && (idx_q == 2'd3);

    // Byte index and pack register; index wraps to 0 after the 4th byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 2'd0;
            pack_q <= '0;
        end else if (clear_i) begin
            idx_q  <= 2'd0;
            pack_q <= '0;
        end else if (load_i) begin
            idx_q  <= idx_q + 2'd1;
            pack_q <= word_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_loader
// Description : Fills instruction memory from a byte stream. Packs 4 bytes
//               (little-endian) per word and writes words to byte addresses
//               0, 4, 8, ... while holding the core. Length 0 finishes
//               immediately; length above MAX_WORDS finishes with err.
//               Optional macro INST_LOADER_CHECKSUM_EN adds a 4-byte trailing
//               checksum (sum mod 2^32 of written words) checked into err.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    inst_mem_loader_if.slave bus
);

    localparam logic [LEN_W-1:0]  c_max_len   = LEN_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] c_addr_step = ADDR_W'(WORD_BYTES);
    localparam logic [LEN_W-1:0]  c_len_one   = LEN_W'(1);

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0]   sum_q, sum_d;
`endif

    logic                pk_load;
    logic                pk_clear;
    logic [WORD_W-1:0]   pk_word;
    logic                pk_full;

    logic                byte_ready;
    logic                mem_we;
    logic                cpu_hold;

    inst_mem_loader_byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (pk_load),
        .clear_i     (pk_clear),
        .byte_i      (bus.byte_data),
        .word_o      (pk_word),
        .word_full_o (pk_full)
    );

    // Next-state, datapath updates and handshake/write outputs
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
`ifdef INST_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        pk_load    = 1'b0;
        pk_clear   = 1'b0;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_hold   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    pk_clear = 1'b1;
                    if (bus.len_words == '0) begin
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else if (bus.len_words > c_max_len) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        len_d      = bus.len_words;
                        word_cnt_d = '0;
                        addr_d     = '0;
                        err_d      = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
                        sum_d      = '0;
`endif
                        state_d    = ST_RECV;
                    end
                end
            end

            ST_RECV: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (bus.byte_valid) begin
                    pk_load = 1'b1;
                    if (pk_full) begin
                        waddr_d = addr_q;
                        wdata_d = pk_word;
                        state_d = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                mem_we     = 1'b1;
                cpu_hold   = 1'b1;
                word_cnt_d = word_cnt_q + c_len_one;
`ifdef INST_LOADER_CHECKSUM_EN
                sum_d      = sum_q + wdata_q;
`endif
                if (word_cnt_q + c_len_one == len_q) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    // Only advanced when another word follows, so the
                    // counter stops at the last written address
                    addr_d  = addr_q + c_addr_step;
                    state_d = ST_RECV;
                end
            end

`ifdef INST_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (bus.byte_valid) begin
                    pk_load = 1'b1;
                    if (pk_full) begin
                        err_d   = (pk_word != sum_q);
                        state_d = ST_DONE;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Length, counters, held write address/data and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.mem_we     = mem_we;
    assign bus.mem_waddr  = waddr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.cpu_hold   = cpu_hold;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.err        = err_q;

endmodule
`default_nettype wire

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Write-side counterpart of the instruction memory read port; fills instruction memory before the core runs.
- Accepts a byte stream over a valid/ready handshake, such as bytes from a UART receiver or a host bridge.
- Packs each 4 bytes, little-endian, into a 32-bit instruction and issues a single-cycle write at word-aligned byte addresses 0, 4, 8, …
- Holds the core in reset while loading.

Parameters:
- ADDR_W, 10, byte-address width of instruction memory (matches the 10-bit fetch address).
- MAX_WORDS, 256, memory depth in words (2^ADDR_W / 4).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- len_words  in  9  number of instructions to load; latched on start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  incoming program byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write enable, one-cycle pulse.
- mem_waddr  out  ADDR_W  byte address of the write, always a multiple of 4.
- mem_wdata  out  32  instruction word.
- cpu_hold  out  1  high while busy; drives core reset/stall.
- done  out  1  sticky high after a successful or aborted load; cleared by the next start.
- err  out  1  sticky: length error (or checksum error, see feature); cleared by the next start.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, address counter 0, word counter 0, byte index 0, pack register 0.
- States: IDLE, RECV, WRITE, DONE (plus CHECK with the feature).
- IDLE:
  - byte_ready = 0 and cpu_hold = 0.
  - On start with len_words = 0: go to DONE with err = 0.
  - On start with len_words > MAX_WORDS: go to DONE with err = 1. No writes occur.
  - Otherwise: latch the length, clear counters, clear done/err, go to RECV.
- RECV:
  - byte_ready = 1 and cpu_hold = 1.
  - A byte transfers when byte_valid && byte_ready.
  - Byte k of a word (k = 0..3) lands in bits [8k+7:8k].
  - When the 4th byte transfers, go to WRITE.
- WRITE (exactly 1 cycle):
  - mem_we = 1, mem_waddr = 4·word_count, mem_wdata = packed word.
  - byte_ready = 0; any byte presented this cycle is not consumed.
  - Then word_count increments.
  - If word_count + 1 == len, go to DONE; otherwise return to RECV.
- Timing: write latency is 1 cycle after the 4th byte handshake. Sustained throughput is 4 bytes per 5 cycles.
- DONE: done = 1 and cpu_hold = 0. The next start restarts as from IDLE.
- The address counter is ADDR_W bits. The length check guarantees it never wraps; the last write address is 4·(MAX_WORDS−1) = 1020.
- mem_waddr/mem_wdata hold their last values when mem_we = 0.
- start outside IDLE/DONE is ignored.
- Async reset mid-load:
  - mem_we drops immediately.
  - Partial words are discarded, and already-written words are not rolled back.
  - The FSM returns to IDLE.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- With the macro:
  - After the last WRITE, the FSM enters CHECK and receives 4 more bytes (little-endian) as the expected checksum. These bytes are not written to memory.
  - The checksum is the sum mod 2^32 of all written words.
  - On mismatch, err = 1. Either way, go to DONE.
  - len_words = 0 goes directly to DONE without a checksum phase.
- Without the macro: no CHECK state, and err reflects only the length error.

Decomposition:
- Shared include/package loader_defs:
  - FSM state encodings (IDLE=0, RECV=1, WRITE=2, DONE=3, CHECK=4), 3-bit state width.
  - WORD_BYTES = 4.
  - Checksum width 32.
- One sub-module, byte_packer:
  - Holds the 2-bit byte index and the 32-bit pack register.
  - Inputs: a load strobe and a clear.
  - Outputs: the word and a word_full pulse.

Test Plan:
- Reset then idle: rst_n low for 3 cycles → all outputs 0; start never asserted → byte_ready stays 0, no mem_we.
- Basic load: start with len=2, bytes 13 05 00 00 93 05 10 00 → writes (0, 0x00000513) then (4, 0x00100593); done = 1, err = 0, cpu_hold low afterward.
- Backpressure and gaps: byte_valid toggled randomly, with a byte held valid during WRITE → that byte is consumed only after RECV resumes; data is intact with no duplicate or missing byte.
- Length boundaries:
  - len = 0 → done next cycle, no writes.
  - len = 257 → done, err = 1, no writes.
  - len = 256 → last write at address 1020, no wrap.
- Reset mid-load: rst_n low after 6 bytes of a len=4 load → mem_we 0, FSM IDLE; new start with len=1 writes address 0 cleanly.
- With INST_LOADER_CHECKSUM_EN: len=2 with the words above plus checksum 0x00100AA6 → err = 0. Checksum 0x00000000 → err = 1. In both cases only 2 memory writes occur.
